// File: rtl/reg_op_unit.sv
// Registered operator unit: bitwise, arithmetic, reduction, logical and
// accumulate ops on a/b with valid/ready handshakes and an optional input stage.
module reg_op_unit #(
  parameter int WIDTH  = 4,
  parameter bit REG_IN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             op_err
);

  typedef enum logic [3:0] {
    OP_AND     = 4'd0,
    OP_OR      = 4'd1,
    OP_XOR     = 4'd2,
    OP_ADD     = 4'd3,
    OP_SUB     = 4'd4,
    OP_RAND    = 4'd5,
    OP_ROR     = 4'd6,
    OP_RXOR    = 4'd7,
    OP_LAND    = 4'd8,
    OP_LOR     = 4'd9,
    OP_ACC_ADD = 4'd10,
    OP_ACC_CLR = 4'd11
  } op_e;

  localparam logic [WIDTH-2:0] PAD = '0;

  logic             adv;
  logic             src_valid;
  logic [3:0]       src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             op_err_q, op_err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   sum_acc;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  generate
    if (REG_IN) begin : g_in_reg
      logic             s1_valid_q;
      logic [3:0]       s1_op_q;
      logic [WIDTH-1:0] s1_a_q;
      logic [WIDTH-1:0] s1_b_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_valid_q <= 1'b0;
        end else if (adv) begin
          s1_valid_q <= in_valid;
        end
      end

      // NOTE: operand payload is qualified by s1_valid_q, so it needs no reset.
      always_ff @(posedge CLK) begin
        if (adv) begin
          s1_op_q <= op;
          s1_a_q  <= a;
          s1_b_q  <= b;
        end
      end

      assign src_valid = s1_valid_q;
      assign src_op    = s1_op_q;
      assign src_a     = s1_a_q;
      assign src_b     = s1_b_q;
    end else begin : g_no_in_reg
      assign src_valid = in_valid;
      assign src_op    = op;
      assign src_a     = a;
      assign src_b     = b;
    end
  endgenerate

  assign sum_ab  = {1'b0, src_a} + {1'b0, src_b};
  assign diff_ab = {1'b0, src_a} - {1'b0, src_b};
  assign sum_acc = {1'b0, acc_q} + {1'b0, src_a};

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    op_err_d = 1'b0;
    acc_d    = acc_q;
    case (src_op)
      OP_AND:     result_d = src_a & src_b;
      OP_OR:      result_d = src_a | src_b;
      OP_XOR:     result_d = src_a ^ src_b;
      OP_ADD: begin
        result_d = sum_ab[WIDTH-1:0];
        carry_d  = sum_ab[WIDTH];
      end
      OP_SUB: begin
        result_d = diff_ab[WIDTH-1:0];
        carry_d  = diff_ab[WIDTH];
      end
      OP_RAND:    result_d = {PAD, &src_a};
      OP_ROR:     result_d = {PAD, |src_a};
      OP_RXOR:    result_d = {PAD, ^src_a};
      OP_LAND:    result_d = {PAD, (|src_a) && (|src_b)};
      OP_LOR:     result_d = {PAD, (|src_a) || (|src_b)};
      OP_ACC_ADD: begin
        result_d = sum_acc[WIDTH-1:0];
        carry_d  = sum_acc[WIDTH];
        acc_d    = sum_acc[WIDTH-1:0];
      end
      OP_ACC_CLR: acc_d = '0;
      default:    op_err_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      op_err_q    <= 1'b0;
      acc_q       <= '0;
    end else if (adv) begin
      out_valid_q <= src_valid;
      // Bubbles keep the last result; the accumulator moves only on real beats.
      if (src_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= zero_d;
        op_err_q <= op_err_d;
        acc_q    <= acc_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_reg_op_unit.sv
// Bench for reg_op_unit: a 4-bit unit with input stage and a 16-bit unit
// without, driven by directed and random beats against a transaction-level model.
module tb_reg_op_unit;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iv   [2];
  logic        ordy [2];
  logic [3:0]  opv  [2];
  logic [15:0] av   [2];
  logic [15:0] bv   [2];

  logic        ird0, ov0, cy0, zr0, er0;
  logic [3:0]  rs0;
  logic        ird1, ov1, cy1, zr1, er1;
  logic [15:0] rs1;

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   fifo [2][64];
  int     head [2];
  int     tail [2];
  longint macc [2];

  always #5 CLK = ~CLK;

  reg_op_unit #(.WIDTH(4), .REG_IN(1'b1)) u_w4 (
    .CLK(CLK), .RST(RST),
    .in_valid(iv[0]), .in_ready(ird0), .op(opv[0]),
    .a(av[0][3:0]), .b(bv[0][3:0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .result(rs0), .carry(cy0), .zero(zr0), .op_err(er0)
  );

  reg_op_unit #(.WIDTH(16), .REG_IN(1'b0)) u_w16 (
    .CLK(CLK), .RST(RST),
    .in_valid(iv[1]), .in_ready(ird1), .op(opv[1]),
    .a(av[1]), .b(bv[1]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .result(rs1), .carry(cy1), .zero(zr1), .op_err(er1)
  );

  function automatic logic f_irdy(input int k);
    return (k == 0) ? ird0 : ird1;
  endfunction
  function automatic logic f_ovld(input int k);
    return (k == 0) ? ov0 : ov1;
  endfunction
  function automatic logic [15:0] f_res(input int k);
    return (k == 0) ? {12'h000, rs0} : rs1;
  endfunction
  function automatic logic f_cy(input int k);
    return (k == 0) ? cy0 : cy1;
  endfunction
  function automatic logic f_zr(input int k);
    return (k == 0) ? zr0 : zr1;
  endfunction
  function automatic logic f_er(input int k);
    return (k == 0) ? er0 : er1;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Reference model: the op table evaluated with plain integer arithmetic.
  function automatic exp_t model(input int k, input logic [3:0] o,
                                 input logic [15:0] ai, input logic [15:0] bi);
    int     w = (k == 0) ? 4 : 16;
    longint m = longint'(1) << w;
    longint x = longint'(ai) % m;
    longint y = longint'(bi) % m;
    longint r = 0;
    longint s;
    bit     c = 1'b0;
    bit     e = 1'b0;
    exp_t   res;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x ^ y;
      4'd3:  begin s = x + y; r = s % m; c = (s >= m); end
      4'd4:  begin r = (x - y + m) % m; c = (x < y); end
      4'd5:  r = (x == m - 1) ? 1 : 0;
      4'd6:  r = (x != 0) ? 1 : 0;
      4'd7:  r = $countones(x) % 2;
      4'd8:  r = (x != 0 && y != 0) ? 1 : 0;
      4'd9:  r = (x != 0 || y != 0) ? 1 : 0;
      4'd10: begin s = macc[k] + x; r = s % m; c = (s >= m); macc[k] = r; end
      4'd11: begin macc[k] = 0; r = 0; end
      default: e = 1'b1;
    endcase
    res.r = r[15:0];
    res.c = c;
    res.z = (r == 0);
    res.e = e;
    return res;
  endfunction

  // One clock: sample both handshakes before the edge, then advance to edge+1.
  task automatic cycle();
    bit   in_rst;
    exp_t e;
    #1;
    in_rst = RST;
    for (int k = 0; k < 2; k++) begin
      if (!in_rst) begin
        checkb($sformatf("in_ready%0d", k), f_irdy(k), !f_ovld(k) || ordy[k]);
        if (f_ovld(k) && ordy[k]) begin
          if (head[k] == tail[k]) begin
            checkb($sformatf("spurious_beat%0d", k), f_ovld(k), 1'b0);
          end else begin
            e = fifo[k][head[k] % 64];
            head[k]++;
            check($sformatf("sb_result%0d", k), f_res(k), e.r);
            checkb($sformatf("sb_carry%0d", k), f_cy(k), e.c);
            checkb($sformatf("sb_zero%0d", k), f_zr(k), e.z);
            checkb($sformatf("sb_op_err%0d", k), f_er(k), e.e);
          end
        end
        if (iv[k] && f_irdy(k)) begin
          fifo[k][tail[k] % 64] = model(k, opv[k], av[k], bv[k]);
          tail[k]++;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (in_rst) begin
      for (int k = 0; k < 2; k++) begin
        head[k] = 0;
        tail[k] = 0;
        macc[k] = 0;
      end
    end
  endtask

  // Single beat into an idle unit, checked after exactly lat cycles.
  task automatic dir_beat(input int k, input logic [3:0] o, input logic [15:0] ai,
                          input logic [15:0] bi, input logic [15:0] er, input logic ec,
                          input logic ez, input logic ee, input int lat, input string tag);
    ordy[k] = 1'b1;
    iv[k]   = 1'b1;
    opv[k]  = o;
    av[k]   = ai;
    bv[k]   = bi;
    cycle();
    iv[k] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      checkb({tag, "_early"}, f_ovld(k), 1'b0);
      cycle();
    end
    checkb({tag, "_valid"}, f_ovld(k), 1'b1);
    check({tag, "_result"}, f_res(k), er);
    checkb({tag, "_carry"}, f_cy(k), ec);
    checkb({tag, "_zero"}, f_zr(k), ez);
    checkb({tag, "_op_err"}, f_er(k), ee);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  st_op [3];
    logic [15:0] st_a  [3];
    int          issued;

    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; opv[k] = 4'd0; av[k] = 16'd0; bv[k] = 16'd0;
      head[k] = 0; tail[k] = 0; macc[k] = 0;
    end
    repeat (3) cycle();
    RST = 1'b0;

    for (int k = 0; k < 2; k++) begin
      checkb($sformatf("rst_out_valid%0d", k), f_ovld(k), 1'b0);
      check($sformatf("rst_result%0d", k), f_res(k), 16'd0);
      checkb($sformatf("rst_carry%0d", k), f_cy(k), 1'b0);
      checkb($sformatf("rst_zero%0d", k), f_zr(k), 1'b0);
      checkb($sformatf("rst_op_err%0d", k), f_er(k), 1'b0);
      checkb($sformatf("rst_in_ready%0d", k), f_irdy(k), 1'b1);
    end

    dir_beat(0, 4'd3, 16'd9, 16'd8, 16'd1,  1'b1, 1'b0, 1'b0, 2, "t1_add");
    dir_beat(0, 4'd4, 16'd3, 16'd5, 16'd14, 1'b1, 1'b0, 1'b0, 2, "t2_sub");
    dir_beat(0, 4'd6, 16'd0, 16'd0, 16'd0,  1'b0, 1'b1, 1'b0, 2, "t2_ror");
    dir_beat(0, 4'd7, 16'd7, 16'd0, 16'd1,  1'b0, 1'b0, 1'b0, 2, "t2_rxor");

    dir_beat(0, 4'd11, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 2, "t3_clr");
    st_a[0] = 16'd7; st_a[1] = 16'd7; st_a[2] = 16'd3;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; opv[0] = 4'd10; av[0] = st_a[i]; bv[0] = 16'd0;
      cycle();
    end
    iv[0] = 1'b0;
    repeat (4) cycle();
    dir_beat(0, 4'd10, 16'd0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 2, "t3_acc_final");

    st_op[0] = 4'd0; st_op[1] = 4'd2; st_op[2] = 4'd3;
    st_a[0] = 16'hC; st_a[1] = 16'h5; st_a[2] = 16'hF;
    issued = 0;
    ordy[0] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (issued < 3) begin
        iv[0] = 1'b1; opv[0] = st_op[issued]; av[0] = st_a[issued]; bv[0] = 16'hA;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (iv[0] && ird0) issued++;
      #1;
      cycle();
      #1;
      if (c >= 2) begin
        checkb("t4_stall_in_ready", ird0, 1'b0);
        check("t4_stall_result", f_res(0), fifo[0][head[0] % 64].r);
      end
    end
    check("t4_issued_before_release", 16'(issued), 16'd2);
    ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (issued < 3) begin
        iv[0] = 1'b1; opv[0] = st_op[issued]; av[0] = st_a[issued]; bv[0] = 16'hA;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (iv[0] && ird0) issued++;
      #1;
      cycle();
    end
    check("t4_drained", 16'(tail[0] - head[0]), 16'd0);

    dir_beat(0, 4'd13, 16'd5, 16'd6, 16'd0, 1'b0, 1'b1, 1'b1, 2, "t5_illegal");
    dir_beat(0, 4'd10, 16'd0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 2, "t5_acc_kept");

    ordy[0] = 1'b0;
    iv[0] = 1'b1; opv[0] = 4'd10; av[0] = 16'd5;
    cycle();
    iv[0] = 1'b0;
    cycle();
    cycle();
    checkb("t6_stalled", ov0, 1'b1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    checkb("t6_rst_out_valid", ov0, 1'b0);
    checkb("t6_rst_in_ready", ird0, 1'b1);
    ordy[0] = 1'b1;
    dir_beat(0, 4'd10, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 2, "t6_acc_zero");

    RST = 1'b1;
    iv[0] = 1'b1; opv[0] = 4'd10; av[0] = 16'd3;
    cycle();
    RST = 1'b0;
    iv[0] = 1'b0;
    cycle();
    checkb("rst_beat_dropped_a", ov0, 1'b0);
    cycle();
    checkb("rst_beat_dropped_b", ov0, 1'b0);
    dir_beat(0, 4'd10, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 2, "rst_beat_acc");

    dir_beat(1, 4'd3, 16'hFFFF, 16'd1, 16'd0,    1'b1, 1'b1, 1'b0, 1, "t6_w16_add");
    dir_beat(1, 4'd4, 16'd2,    16'd3, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1, "t6_w16_sub");

    repeat (800) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        opv[k]  = 4'($urandom_range(0, 15));
        av[k]   = 16'($urandom);
        bv[k]   = 16'($urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (6) cycle();
    check("rand_drained0", 16'(tail[0] - head[0]), 16'd0);
    check("rand_drained1", 16'(tail[1] - head[1]), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
